// File: rtl/vectored_interrupt_controller_if.sv
// Interrupt controller bus: CPU-side strobes and requests in, status/take out.
// master = CPU/decoder side, slave = controller side.
interface vectored_interrupt_controller_if #(
  parameter int unsigned NUM_INT    = 4,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  COMMIT;
  logic                  EIX;
  logic                  DIX;
  logic                  RETIX;
  logic [NUM_INT-1:0]    INT;
  logic                  MASK_WR;
  logic [NUM_INT-1:0]    MASK_DIN;
  logic [NUM_INT-1:0]    MASK;
  logic [NUM_INT-1:0]    PENDING;
  logic [NUM_INT-1:0]    IN_SERVICE;
  logic                  IE;
  logic                  INT_TAKE;
  logic [ADDR_WIDTH-1:0] VECTOR;
  logic                  CC_SAVE;
  logic                  CC_RESTORE;

  modport master (
    output COMMIT, EIX, DIX, RETIX, INT,
    output MASK_WR, MASK_DIN,
    input  MASK, PENDING, IN_SERVICE, IE,
    input  INT_TAKE, VECTOR, CC_SAVE, CC_RESTORE
  );

  modport slave (
    input  COMMIT, EIX, DIX, RETIX, INT,
    input  MASK_WR, MASK_DIN,
    output MASK, PENDING, IN_SERVICE, IE,
    output INT_TAKE, VECTOR, CC_SAVE, CC_RESTORE
  );
endinterface

// File: rtl/vectored_interrupt_controller.sv
// N-channel fixed-priority nesting interrupt controller with vectored take.
// Ports: CLK, RESET (sync, active-high), bus (slave modport of the _if).
module vectored_interrupt_controller #(
  parameter int unsigned          NUM_INT       = 4,
  parameter int unsigned          ADDR_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE  = 'h0004,
  parameter int unsigned          VECTOR_STRIDE = 4,
  parameter logic [NUM_INT-1:0]   EDGE_SENSE    = '1
) (
  input logic CLK,
  input logic RESET,
  vectored_interrupt_controller_if.slave bus
);

  localparam int unsigned IDX_W =
    (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE =
    ADDR_WIDTH'(VECTOR_STRIDE);

  logic [NUM_INT-1:0]    sync1;
  logic [NUM_INT-1:0]    sync2;
  logic [NUM_INT-1:0]    prev;
  logic [1:0]            warm;
  logic [NUM_INT-1:0]    pend;
  logic [NUM_INT-1:0]    in_svc;
  logic [NUM_INT-1:0]    mask;
  logic                  ie;
  logic                  take_q;
  logic                  rest_q;
  logic [ADDR_WIDTH-1:0] vec;

  logic [NUM_INT-1:0]    rise;
  logic [NUM_INT-1:0]    below;
  logic [NUM_INT-1:0]    elig;
  logic [NUM_INT-1:0]    win_oh;
  logic [NUM_INT-1:0]    svc_low;
  logic [NUM_INT-1:0]    clr;
  logic [NUM_INT-1:0]    pend_nxt;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_vld;
  logic                  take_go;
  logic                  ret_go;
  logic                  blocked;

  // prev is held at 1 until the synchroniser carries real samples, so
  // an input already high across reset needs a fresh rise to latch.
  assign rise = sync2 & ~prev;

  always_comb begin
    below   = '0;
    blocked = 1'b0;
    for (int i = 0; i < int'(NUM_INT); i++) begin
      blocked  = blocked | in_svc[i];
      below[i] = ~blocked;
    end
  end

  assign svc_low = in_svc & (~in_svc + NUM_INT'(1));
  assign elig    = pend & mask & below & {NUM_INT{ie}};
  assign win_oh  = elig & (~elig + NUM_INT'(1));
  assign win_vld = |elig;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < int'(NUM_INT); i++) begin
      if (win_oh[i]) win_idx = IDX_W'(i);
    end
  end

  assign take_go = bus.COMMIT & win_vld & ~bus.EIX
                 & ~bus.DIX & ~bus.RETIX;
  assign ret_go  = bus.COMMIT & bus.RETIX & (|in_svc);
  assign clr     = take_go ? win_oh : '0;

  // Edge channels: set beats take-clear. Level channels track sync2.
  assign pend_nxt = (EDGE_SENSE & ((pend & ~clr) | rise))
                  | (~EDGE_SENSE & sync2);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '1;
      warm   <= '0;
      pend   <= '0;
      in_svc <= '0;
      mask   <= '0;
      ie     <= 1'b0;
      take_q <= 1'b0;
      rest_q <= 1'b0;
      vec    <= '0;
    end else begin
      sync1  <= bus.INT;
      sync2  <= sync1;
      warm   <= {warm[0], 1'b1};
      prev   <= warm[1] ? sync2 : '1;
      pend   <= pend_nxt;
      in_svc <= (in_svc | clr)
              & ~(ret_go ? svc_low : '0);
      if (bus.MASK_WR) mask <= bus.MASK_DIN;
      if (bus.COMMIT & bus.DIX)      ie <= 1'b0;
      else if (bus.COMMIT & bus.EIX) ie <= 1'b1;
      take_q <= take_go;
      rest_q <= ret_go;
      if (take_go)
        vec <= VECTOR_BASE + ADDR_WIDTH'(win_idx) * STRIDE;
    end
  end

  assign bus.MASK       = mask;
  assign bus.PENDING    = pend;
  assign bus.IN_SERVICE = in_svc;
  assign bus.IE         = ie;
  assign bus.INT_TAKE   = take_q;
  assign bus.CC_SAVE    = take_q;
  assign bus.VECTOR     = vec;
  assign bus.CC_RESTORE = rest_q;

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Bench for vectored_interrupt_controller: directed plan plus random run.
// Ch3 is level-sensed; every cycle is compared with a behavioural model.
module tb_vectored_interrupt_controller;

  localparam logic [3:0] EDGE = 4'b0111;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vectored_interrupt_controller_if #(
    .NUM_INT(4), .ADDR_WIDTH(16)
  ) bus ();

  vectored_interrupt_controller #(
    .NUM_INT(4),
    .ADDR_WIDTH(16),
    .VECTOR_BASE(16'h0004),
    .VECTOR_STRIDE(4),
    .EDGE_SENSE(EDGE)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  // model state and next state
  logic        m_ie, m_take, m_rest;
  logic [3:0]  m_mask, m_pend, m_is;
  logic [15:0] m_vec;
  logic        n_ie, n_take, n_rest;
  logic [3:0]  n_mask, n_pend, n_is;
  logic [15:0] n_vec;
  logic [3:0]  hist[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Rules applied at one rising edge, from pre-edge state and inputs.
  task automatic model_eval();
    int lo, win, sz;
    bit take, ret, rose;
    if (rst) begin
      n_ie = 0; n_take = 0; n_rest = 0;
      n_mask = 0; n_pend = 0; n_is = 0; n_vec = 0;
      return;
    end
    lo = 4;
    for (int i = 3; i >= 0; i--) if (m_is[i]) lo = i;
    win = -1;
    for (int i = 3; i >= 0; i--)
      if (m_pend[i] && m_mask[i] && m_ie && i < lo) win = i;
    take = bus.COMMIT && win >= 0 && !bus.EIX
        && !bus.DIX && !bus.RETIX;
    ret  = bus.COMMIT && bus.RETIX && lo < 4;
    sz = hist.size();
    for (int i = 0; i < 4; i++) begin
      if (!EDGE[i]) begin
        n_pend[i] = (sz >= 2) ? hist[sz-2][i] : 1'b0;
      end else begin
        rose = sz >= 3 && hist[sz-2][i] && !hist[sz-3][i];
        if (rose) n_pend[i] = 1'b1;
        else if (take && win == i) n_pend[i] = 1'b0;
        else n_pend[i] = m_pend[i];
      end
    end
    n_is = m_is;
    if (take) n_is[win] = 1'b1;
    if (ret) n_is[lo] = 1'b0;
    n_ie = m_ie;
    if (bus.COMMIT && bus.DIX) n_ie = 1'b0;
    else if (bus.COMMIT && bus.EIX) n_ie = 1'b1;
    n_mask = bus.MASK_WR ? bus.MASK_DIN : m_mask;
    n_take = take;
    n_rest = ret;
    n_vec  = take ? 16'h0004 + 16'(win) * 16'd4 : m_vec;
  endtask

  task automatic model_commit(input logic r, input logic [3:0] s);
    m_ie = n_ie; m_take = n_take; m_rest = n_rest;
    m_mask = n_mask; m_pend = n_pend; m_is = n_is;
    m_vec = n_vec;
    if (r) hist.delete();
    else begin
      hist.push_back(s);
      if (hist.size() > 3) void'(hist.pop_front());
    end
  endtask

  task automatic check_all();
    chk("mdl_mask", 32'(bus.MASK), 32'(m_mask));
    chk("mdl_pend", 32'(bus.PENDING), 32'(m_pend));
    chk("mdl_is", 32'(bus.IN_SERVICE), 32'(m_is));
    chk("mdl_ie", 32'(bus.IE), 32'(m_ie));
    chk("mdl_take", 32'(bus.INT_TAKE), 32'(m_take));
    chk("mdl_save", 32'(bus.CC_SAVE), 32'(m_take));
    chk("mdl_rest", 32'(bus.CC_RESTORE), 32'(m_rest));
    chk("mdl_vec", 32'(bus.VECTOR), 32'(m_vec));
  endtask

  task automatic step(input int n = 1);
    logic r;
    logic [3:0] s;
    for (int k = 0; k < n; k++) begin
      r = rst;
      s = bus.INT;
      model_eval();
      @(posedge clk);
      #1;
      model_commit(r, s);
      check_all();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.COMMIT = 0; bus.EIX = 0; bus.DIX = 0; bus.RETIX = 0;
    bus.INT = 0; bus.MASK_WR = 0; bus.MASK_DIN = 0;
    m_ie = 0; m_take = 0; m_rest = 0;
    m_mask = 0; m_pend = 0; m_is = 0; m_vec = 0;
    step(2);
    chk("rst_ie", 32'(bus.IE), 0);
    chk("rst_mask", 32'(bus.MASK), 0);
    chk("rst_pend", 32'(bus.PENDING), 0);
    chk("rst_is", 32'(bus.IN_SERVICE), 0);
    chk("rst_take", 32'(bus.INT_TAKE), 0);
    chk("rst_vec", 32'(bus.VECTOR), 0);
    chk("rst_rest", 32'(bus.CC_RESTORE), 0);
    rst = 1'b0;
    step(3);

    // basic take of ch2
    bus.MASK_WR = 1; bus.MASK_DIN = 4'hF;
    step();
    bus.MASK_WR = 0;
    chk("mask_f", 32'(bus.MASK), 32'hF);
    bus.COMMIT = 1; bus.EIX = 1;
    step();
    bus.EIX = 0;
    chk("ie_on", 32'(bus.IE), 1);
    bus.INT = 4'b0100;
    step(2);
    chk("pend2_early", 32'(bus.PENDING), 0);
    step();
    chk("pend2_3clk", 32'(bus.PENDING), 32'h4);
    step();
    chk("take2", 32'(bus.INT_TAKE), 1);
    chk("save2", 32'(bus.CC_SAVE), 1);
    chk("vec2", 32'(bus.VECTOR), 32'h000C);
    chk("is2", 32'(bus.IN_SERVICE), 32'h4);
    chk("pend2_clr", 32'(bus.PENDING), 0);
    step();
    chk("take2_pulse", 32'(bus.INT_TAKE), 0);

    // nesting: ch1 over ch2, ch3 waits for two returns
    bus.INT = 4'b1110;
    step(4);
    chk("take1", 32'(bus.INT_TAKE), 1);
    chk("vec1", 32'(bus.VECTOR), 32'h0008);
    chk("is21", 32'(bus.IN_SERVICE), 32'h6);
    step(2);
    chk("no_take3", 32'(bus.INT_TAKE), 0);
    bus.RETIX = 1;
    step();
    bus.RETIX = 0;
    chk("ret1_rest", 32'(bus.CC_RESTORE), 1);
    chk("ret1_is", 32'(bus.IN_SERVICE), 32'h4);
    step();
    chk("still_no3", 32'(bus.INT_TAKE), 0);
    bus.RETIX = 1;
    step();
    bus.RETIX = 0;
    chk("ret2_is", 32'(bus.IN_SERVICE), 0);
    step();
    chk("take3", 32'(bus.INT_TAKE), 1);
    chk("vec3", 32'(bus.VECTOR), 32'h0010);
    chk("is3", 32'(bus.IN_SERVICE), 32'h8);

    // level ch3 held through return is re-taken
    bus.RETIX = 1;
    step();
    bus.RETIX = 0;
    chk("ret3_rest", 32'(bus.CC_RESTORE), 1);
    step();
    chk("retake3", 32'(bus.INT_TAKE), 1);
    chk("revec3", 32'(bus.VECTOR), 32'h0010);
    bus.INT = 4'b0000;
    step(3);
    chk("pend3_drop", 32'(bus.PENDING), 0);
    bus.RETIX = 1;
    step();
    bus.RETIX = 0;
    step(2);
    chk("noretake3", 32'(bus.INT_TAKE), 0);

    // IE off, then one-instruction delay after EIX
    bus.DIX = 1;
    step();
    bus.DIX = 0;
    chk("ie_off", 32'(bus.IE), 0);
    bus.INT = 4'b0001;
    step(3);
    chk("pend0", 32'(bus.PENDING), 32'h1);
    step();
    chk("no_take_ie0", 32'(bus.INT_TAKE), 0);
    bus.EIX = 1;
    step();
    bus.EIX = 0;
    chk("eix_no_take", 32'(bus.INT_TAKE), 0);
    step();
    chk("take0", 32'(bus.INT_TAKE), 1);
    chk("vec0", 32'(bus.VECTOR), 32'h0004);
    bus.RETIX = 1;
    step();
    bus.RETIX = 0;

    // same-cycle rules
    bus.EIX = 1; bus.DIX = 1;
    step();
    bus.EIX = 0; bus.DIX = 0;
    chk("dix_wins", 32'(bus.IE), 0);
    bus.RETIX = 1;
    step();
    bus.RETIX = 0;
    chk("ret_empty", 32'(bus.CC_RESTORE), 0);
    bus.EIX = 1;
    step();
    bus.EIX = 0;
    bus.COMMIT = 0;
    bus.INT = 4'b0011;
    step(3);
    chk("pend1", 32'(bus.PENDING), 32'h2);
    bus.COMMIT = 1; bus.MASK_WR = 1; bus.MASK_DIN = 4'b1101;
    step();
    bus.MASK_WR = 0;
    chk("old_mask_take", 32'(bus.INT_TAKE), 1);
    chk("old_mask_vec", 32'(bus.VECTOR), 32'h0008);
    chk("new_mask", 32'(bus.MASK), 32'hD);

    // reset mid-service, input still high
    rst = 1;
    step();
    rst = 0;
    chk("mid_is", 32'(bus.IN_SERVICE), 0);
    chk("mid_ie", 32'(bus.IE), 0);
    chk("mid_vec", 32'(bus.VECTOR), 0);
    bus.MASK_WR = 1; bus.MASK_DIN = 4'hF; bus.EIX = 1;
    step();
    bus.MASK_WR = 0; bus.EIX = 0;
    step(5);
    chk("stillhigh", 32'(bus.PENDING), 0);
    bus.INT = 0;
    step(4);
    bus.INT = 4'b0010;
    step(3);
    chk("fresh", 32'(bus.PENDING), 32'h2);
    step();
    chk("fresh_take", 32'(bus.VECTOR), 32'h0008);

    // random run against the model
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) bus.INT = 4'($urandom);
      bus.COMMIT   = 1'($urandom_range(0, 1));
      bus.EIX      = ($urandom_range(0, 7) == 0);
      bus.DIX      = ($urandom_range(0, 15) == 0);
      bus.RETIX    = ($urandom_range(0, 5) == 0);
      bus.MASK_WR  = ($urandom_range(0, 9) == 0);
      bus.MASK_DIN = 4'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
